// File: rtl/l1_mem_requester.sv
// L1-side initiator for the main-memory VALID/READY/LOAD/STORE handshake:
// one request at a time, loads become line fills, stores become single-word writes.
module l1_mem_requester #(
  parameter int LINE_WORDS = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic                       REQ_WRITE,
  input  logic [31:0]                REQ_ADDR,
  input  logic [31:0]                REQ_WDATA,
  output logic                       RESP_VALID,
  output logic                       RESP_ERR,
  output logic [32*LINE_WORDS-1:0]   RESP_LINE,
  output logic                       VALID,
  output logic                       LOAD,
  output logic                       STORE,
  input  logic                       READY,
  output logic [31:0]                DATA_OUT,
  input  logic [31:0]                DATA_IN,
  output logic                       ACK_ADDR,
  input  logic [3:0]                 ACK_DATA_MEM,
  output logic [3:0]                 ACK_DATA_L1,
  output logic [2:0]                 dbg_state
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam int KW = IW + 1;
  localparam int AW = IW + 2;
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << AW) - 32'd1);
  localparam logic [15:0] TMO        = 16'(TIMEOUT);
  localparam logic [KW-1:0] LAST_K   = KW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_CLOSE} state_t;

  state_t                       state_q, state_d;
  logic                         write_q, write_d;
  logic [31:0]                  addr_q, addr_d;
  logic [31:0]                  wdata_q, wdata_d;
  logic [KW-1:0]                k_q, k_d;
  logic [15:0]                  cnt_q, cnt_d;
  logic [3:0]                   ack_q, ack_d;
  logic [LINE_WORDS-1:0][31:0]  fill_q, fill_d;
  logic [LINE_WORDS-1:0][31:0]  line_q, line_d;

  logic accept, capture, tmo_hit, done, resp_fire;

  // Request handshake: a request transfers on a clock edge where REQ_VALID and
  // REQ_READY are both 1; REQ_READY depends only on the registered IDLE state.
  assign accept    = (state_q == S_IDLE) && REQ_VALID;
  assign tmo_hit   = (state_q != S_IDLE) && (cnt_q == TMO);
  assign capture   = (state_q == S_DATA) && !write_q && READY && !tmo_hit &&
                     (ACK_DATA_MEM == 4'(k_q));
  assign done      = (state_q == S_CLOSE) && !READY && !tmo_hit;
  assign resp_fire = done || tmo_hit;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      ack_q   <= 4'hF;
      fill_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      fill_q  <= fill_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (REQ_VALID) state_d = S_REQ;
        S_REQ:   if (READY) state_d = S_ADDR;
        S_ADDR:  if (ACK_DATA_MEM == 4'd0) state_d = S_DATA;
        S_DATA: begin
          if (write_q) begin
            if (!READY) state_d = S_CLOSE;
          end else if (capture && (k_q == LAST_K)) begin
            state_d = S_CLOSE;
          end
        end
        S_CLOSE: if (!READY) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    k_d     = k_q;
    ack_d   = ack_q;
    fill_d  = fill_q;
    line_d  = line_q;
    cnt_d   = ((state_d != state_q) || capture || (state_d == S_IDLE)) ? 16'd0 : cnt_q + 16'd1;
    if (accept) begin
      write_d = REQ_WRITE;
      addr_d  = REQ_ADDR;
      wdata_d = REQ_WDATA;
      k_d     = '0;
    end
    if (capture) begin
      fill_d[k_q[IW-1:0]] = DATA_IN;
      ack_d               = 4'(k_q);
      k_d                 = k_q + KW'(1);
    end
    if ((state_q == S_ADDR) && (state_d == S_DATA) && write_q) ack_d = 4'd0;
    // Only a fill that closes normally publishes its line; a timeout keeps the old one.
    if (done && !write_q) line_d = fill_q;
    if (state_d == S_IDLE) ack_d = 4'hF;
  end

  always_comb begin
    REQ_READY  = (state_q == S_IDLE);
    RESP_VALID = resp_fire;
    RESP_ERR   = tmo_hit;
    VALID      = (state_q != S_IDLE) && !resp_fire;
    LOAD       = VALID && !write_q;
    STORE      = VALID && write_q;
    ACK_ADDR   = (state_q == S_ADDR) && !tmo_hit;
    DATA_OUT   = 32'd0;
    if (!tmo_hit) begin
      if (state_q == S_ADDR) DATA_OUT = write_q ? addr_q : (addr_q & ALIGN_MASK);
      else if ((state_q == S_DATA) && write_q) DATA_OUT = wdata_q;
    end
    ACK_DATA_L1 = resp_fire ? 4'hF : ack_q;
    RESP_LINE   = (done && !write_q) ? fill_q : line_q;
    dbg_state   = state_q;
  end
endmodule

// File: tb/tb_l1_mem_requester.sv
// Bench for l1_mem_requester: a table of fill/store transactions played against a
// cycle-stepped memory model, with responses checked from an expected-response queue.
module tb_l1_mem_requester;
  localparam int LW = 8;
  localparam int LINE_W = 32 * LW;
  localparam int W = LINE_W + 1;
  localparam int N = 8;

  logic              CLK, RST_N;
  logic              REQ_VALID, REQ_READY, REQ_WRITE;
  logic [31:0]       REQ_ADDR, REQ_WDATA;
  logic              RESP_VALID, RESP_ERR;
  logic [LINE_W-1:0] RESP_LINE;
  logic              VALID, LOAD, STORE, READY;
  logic [31:0]       DATA_OUT, DATA_IN;
  logic              ACK_ADDR;
  logic [3:0]        ACK_DATA_MEM, ACK_DATA_L1;
  logic [2:0]        dbg_state;

  l1_mem_requester #(.LINE_WORDS(LW), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RESP_VALID(RESP_VALID), .RESP_ERR(RESP_ERR), .RESP_LINE(RESP_LINE),
    .VALID(VALID), .LOAD(LOAD), .STORE(STORE), .READY(READY),
    .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN), .ACK_ADDR(ACK_ADDR),
    .ACK_DATA_MEM(ACK_DATA_MEM), .ACK_DATA_L1(ACK_DATA_L1), .dbg_state(dbg_state)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] base;
    int          gap;
    logic [31:0] exp_addr;
    bit          rep;
    int          rst_at;
    bit          no_ready;
    bit          keep_valid;
    bit          chained;
  } vec_t;

  vec_t              tbl[N];
  logic [W-1:0]      exp_q[$];
  logic [LINE_W-1:0] last_line;
  logic [W-1:0]      e;
  int                checks, errors, cyc, resp_cyc;

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every response is popped against the oldest expectation
  always @(negedge CLK) begin
    if (RST_N && RESP_VALID) begin
      resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=1 required=0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("resp_err", 32'(RESP_ERR), 32'(e[LINE_W]));
        chk_line("resp_line", RESP_LINE, e[LINE_W-1:0]);
        chk("resp_valid_dropped", 32'(VALID), 32'd0);
        chk("resp_req_ready", 32'(REQ_READY), 32'd0);
      end
    end
  end

  // driver + memory model for one transaction
  task automatic run_txn(input vec_t v, input vec_t nxt);
    int n;
    int d;
    int hold;
    logic [LINE_W-1:0] ln;
    logic [3:0] prev;
    REQ_VALID = 1'b1;
    REQ_WRITE = v.write;
    REQ_ADDR  = v.addr;
    REQ_WDATA = v.wdata;
    if (v.no_ready || v.write) begin
      exp_q.push_back({v.no_ready, last_line});
    end else begin
      for (int k = 0; k < LW; k++) ln[32*k +: 32] = v.base + 32'(k);
      last_line = ln;
      exp_q.push_back({1'b0, ln});
    end
    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 40) begin
      tick();
      @(negedge CLK);
      n++;
    end
    chk("req_accept_wait", 32'(n < 40), 32'd1);
    tick();
    if (v.keep_valid) begin
      REQ_WRITE = nxt.write;
      REQ_ADDR  = nxt.addr;
      REQ_WDATA = nxt.wdata;
    end else begin
      REQ_VALID = 1'b0;
    end
    @(negedge CLK);
    chk("valid_open", 32'(VALID), 32'd1);
    chk("load_flag", 32'(LOAD), 32'(!v.write));
    chk("store_flag", 32'(STORE), 32'(v.write));
    chk("req_ready_busy", 32'(REQ_READY), 32'd0);
    if (v.chained) chk("b2b_gap", 32'(cyc - resp_cyc), 32'd2);

    if (v.no_ready) begin
      n = 0;
      while (!RESP_VALID && n < 40) begin
        tick();
        @(negedge CLK);
        n++;
      end
      chk("timeout_cycles", 32'(n), 32'd16);
      tick();
      return;
    end

    d = $urandom_range(0, 2);
    for (int i = 0; i < d; i++) begin
      tick();
      @(negedge CLK);
      chk("valid_hold", 32'(VALID), 32'd1);
    end
    tick();
    READY = 1'b1;
    tick();
    @(negedge CLK);
    chk("ack_addr_hold", 32'(ACK_ADDR), 32'd1);
    tick();
    ACK_DATA_MEM = 4'd0;
    DATA_IN      = v.base;
    @(negedge CLK);
    chk("ack_addr", 32'(ACK_ADDR), 32'd1);
    chk("addr_out", DATA_OUT, v.exp_addr);
    tick();

    if (v.write) begin
      ACK_DATA_MEM = 4'hF;
      for (int i = 0; i < 3; i++) begin
        @(negedge CLK);
        chk("store_data", DATA_OUT, v.wdata);
        chk("store_ack", 32'(ACK_DATA_L1), 32'd0);
        tick();
      end
      READY = 1'b0;
      @(negedge CLK);
      chk("store_valid", 32'(VALID), 32'd1);
      tick();
      @(negedge CLK);
      chk("store_resp", 32'(RESP_VALID), 32'd1);
      tick();
      return;
    end

    for (int w = 0; w < LW; w++) begin
      hold = (v.rep && w == 2) ? 4 : v.gap;
      prev = (w == 0) ? 4'hF : 4'(w - 1);
      if (v.rep && w == 3) begin
        ACK_DATA_MEM = 4'd5;
        DATA_IN      = 32'hBAD0_0005;
        @(negedge CLK);
        chk("ack_out_of_order", 32'(ACK_DATA_L1), 32'd2);
        tick();
      end
      for (int h = 0; h < hold; h++) begin
        ACK_DATA_MEM = 4'(w);
        DATA_IN      = v.base + 32'(w);
        @(negedge CLK);
        if (w == 0 && h == 0) chk("ack_addr_drop", 32'(ACK_ADDR), 32'd0);
        chk("ack_step", 32'(ACK_DATA_L1), (h == 0) ? 32'(prev) : 32'(w));
        tick();
      end
      if (w == v.rst_at) begin
        RST_N        = 1'b0;
        READY        = 1'b0;
        ACK_DATA_MEM = 4'hF;
        REQ_VALID    = 1'b0;
        void'(exp_q.pop_back());
        last_line = '0;
        tick();
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_req_ready", 32'(REQ_READY), 32'd1);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_ack", 32'(ACK_DATA_L1), 32'hF);
        chk("rst_data_out", DATA_OUT, 32'd0);
        chk_line("rst_line", RESP_LINE, '0);
        tick();
        return;
      end
    end
    ACK_DATA_MEM = 4'hF;
    @(negedge CLK);
    chk("ack_last", 32'(ACK_DATA_L1), 32'd7);
    chk("close_hold", 32'(VALID), 32'd1);
    chk("close_no_resp", 32'(RESP_VALID), 32'd0);
    tick();
    READY = 1'b0;
    @(negedge CLK);
    chk("load_resp", 32'(RESP_VALID), 32'd1);
    chk("ack_none", 32'(ACK_DATA_L1), 32'hF);
    tick();
  endtask

  initial begin
    vec_t nxt;
    checks = 0; errors = 0; cyc = 0; resp_cyc = 0;
    last_line = '0;
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    READY = 1'b0; DATA_IN = '0; ACK_DATA_MEM = 4'hF;
    repeat (3) tick();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("reset_req_ready", 32'(REQ_READY), 32'd1);
    chk("reset_valid", 32'(VALID), 32'd0);
    chk("reset_load_store", 32'({LOAD, STORE, ACK_ADDR}), 32'd0);
    chk("reset_resp", 32'({RESP_VALID, RESP_ERR}), 32'd0);
    chk("reset_ack", 32'(ACK_DATA_L1), 32'hF);
    chk("reset_data_out", DATA_OUT, 32'd0);
    chk_line("reset_line", RESP_LINE, '0);
    tick();

    //           write addr           wdata          base           gap exp_addr       rep rst nordy keep chain
    tbl[0] = '{1'b0, 32'h0000_0047, 32'h0,         32'h0000_00A0, 2, 32'h0000_0040, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1, 32'h0000_0010, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h1234_567F, 32'h0,         32'h0000_0100, 1, 32'h1234_5660, 1'b1, -1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0200, 32'h0,         32'h0000_0300, 2, 32'h0000_0200, 1'b0,  4, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0000_4000, 3, 32'hFFFF_FFE0, 1'b0, -1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0003, 32'h1234_5678, 32'h0,         1, 32'h0000_0003, 1'b0, -1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 32'h0000_0080, 32'h0,         32'h0,         1, 32'h0000_0080, 1'b0, -1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 32'h0000_0055, 32'hCAFE_F00D, 32'h0,         1, 32'h0000_0055, 1'b0, -1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < N; i++) begin
      if (i + 1 < N) nxt = tbl[i + 1];
      else nxt = tbl[i];
      run_txn(tbl[i], nxt);
    end
    repeat (3) tick();
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
